// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory port between the instruction fetch unit
//            (read-only) and the load/store unit (read/write). Round-robin
//            arbitration, one outstanding transaction, request payload
//            registered so it stays stable for the whole memory handshake.
// Ports    : i_clk, i_rst          clock, synchronous active-high reset
//            i_ifu_* / o_ifu_*     IFU request (valid/ready/addr) + response
//            i_lsu_* / o_lsu_*     LSU request (valid/ready/wen/addr/wdata/
//                                  wmask) + response
//            o_mem_* / i_mem_*     registered memory request + response
//            o_busy                transaction in progress (state != IDLE)
//            o_err                 sticky: memory response seen outside WAIT
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic            i_ifu_valid,
  output logic            o_ifu_ready,
  input  logic [AW-1:0]   i_ifu_addr,
  output logic            o_ifu_rvalid,
  output logic [DW-1:0]   o_ifu_rdata,

  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic            i_lsu_wen,
  input  logic [AW-1:0]   i_lsu_addr,
  input  logic [DW-1:0]   i_lsu_wdata,
  input  logic [DW/8-1:0] i_lsu_wmask,
  output logic            o_lsu_rvalid,
  output logic [DW-1:0]   o_lsu_rdata,

  output logic            o_mem_valid,
  input  logic            i_mem_ready,
  output logic            o_mem_wen,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_wmask,
  input  logic            i_mem_rvalid,
  input  logic [DW-1:0]   i_mem_rdata,

  output logic            o_busy,
  output logic            o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_grant_q, last_grant_d;
  logic             wen_q, wen_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW/8-1:0]  wmask_q, wmask_d;
  logic             err_q, err_d;

  logic             ifu_grant;
  logic             lsu_grant;
  logic             ifu_rsp;
  logic             lsu_rsp;

  // Tie-break: the requester that did not win last time gets the grant.
  // last_grant resets to IFU, so the LSU wins the first tie after reset.
  always_comb begin
    ifu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (state_q == S_IDLE && !i_rst) begin
      lsu_grant = i_lsu_valid && (!i_ifu_valid || last_grant_q == OWN_IFU);
      ifu_grant = i_ifu_valid && (!i_lsu_valid || last_grant_q == OWN_LSU);
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    // Any memory response outside WAIT is stray (includes one that arrives
    // together with i_mem_ready in REQ).
    err_d        = err_q | (i_mem_rvalid && state_q != S_WAIT);
    ifu_rsp      = 1'b0;
    lsu_rsp      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (lsu_grant) begin
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          wen_d        = i_lsu_wen;
          addr_d       = i_lsu_addr;
          wdata_d      = i_lsu_wdata;
          // Reads always present an all-zero strobe to memory.
          wmask_d      = i_lsu_wen ? i_lsu_wmask : '0;
          state_d      = S_REQ;
        end else if (ifu_grant) begin
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          wen_d        = 1'b0;
          addr_d       = i_ifu_addr;
          wdata_d      = '0;
          wmask_d      = '0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (i_mem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          // Suppressed during reset: an in-flight transaction is dropped.
          ifu_rsp = !i_rst && owner_q == OWN_IFU;
          lsu_rsp = !i_rst && owner_q == OWN_LSU;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_IFU;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      err_q        <= err_d;
    end
  end

  assign o_ifu_ready  = ifu_grant;
  assign o_lsu_ready  = lsu_grant;

  assign o_ifu_rvalid = ifu_rsp;
  assign o_lsu_rvalid = lsu_rsp;
  assign o_ifu_rdata  = ifu_rsp ? i_mem_rdata : '0;
  assign o_lsu_rdata  = lsu_rsp ? i_mem_rdata : '0;

  assign o_mem_valid  = (state_q == S_REQ);
  assign o_mem_wen    = wen_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_wmask  = wmask_q;

  assign o_busy       = (state_q != S_IDLE);
  assign o_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. Inputs change 1 ns
//            after the rising edge and outputs are sampled 1 ns later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_valid = 1'b0;
  logic        ifu_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ifu_valid(ifu_valid), .o_ifu_ready(ifu_ready), .i_ifu_addr(ifu_addr),
    .o_ifu_rvalid(ifu_rvalid), .o_ifu_rdata(ifu_rdata),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_wen(lsu_wen),
    .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
    .o_lsu_rvalid(lsu_rvalid), .o_lsu_rdata(lsu_rdata),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_wen(mem_wen),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_busy(busy), .o_err(err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    tests++; if ({mem_wen, mem_wdata, mem_wmask} !== 37'h0) begin fails++; $display("FAIL reset_mem_payload got %h want 0", {mem_wen, mem_wdata, mem_wmask}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    tests++; if ({ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid} !== 4'b0) begin fails++; $display("FAIL reset_handshakes got %b want 0000", {ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid}); end
  endtask

  task automatic test_ifu_read();
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0000;
    #1;
    tests++; if (ifu_ready !== 1'b1) begin fails++; $display("FAIL ifu_accept_ready got %b want 1", ifu_ready); end
    tests++; if (lsu_ready !== 1'b0) begin fails++; $display("FAIL ifu_accept_lsu_ready got %b want 0", lsu_ready); end
    cyc();
    ifu_valid = 1'b0; ifu_addr = 32'hFFFF_FFFF;  // must not disturb latched address
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mem_ready = 1'b1;
      #1;
      tests++; if (mem_valid !== 1'b1) begin fails++; $display("FAIL ifu_req_valid c%0d got %b want 1", k, mem_valid); end
      tests++; if ({mem_addr, mem_wen, mem_wmask} !== {32'h8000_0000, 1'b0, 4'h0}) begin fails++; $display("FAIL ifu_req_payload c%0d got %h want %h", k, {mem_addr, mem_wen, mem_wmask}, {32'h8000_0000, 1'b0, 4'h0}); end
      tests++; if (ifu_ready !== 1'b0) begin fails++; $display("FAIL ifu_req_ready c%0d got %b want 0", k, ifu_ready); end
      cyc();
    end
    mem_ready = 1'b0;
    #1;
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL ifu_wait_mem_valid got %b want 0", mem_valid); end
    tests++; if (ifu_rvalid !== 1'b0 || ifu_rdata !== 32'h0) begin fails++; $display("FAIL ifu_wait_idle_rsp got %b/%h want 0/0", ifu_rvalid, ifu_rdata); end
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
    #1;
    tests++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413) begin fails++; $display("FAIL ifu_rsp got %b/%h want 1/00000413", ifu_rvalid, ifu_rdata); end
    tests++; if (lsu_rvalid !== 1'b0 || lsu_rdata !== 32'h0) begin fails++; $display("FAIL ifu_rsp_lsu_quiet got %b/%h want 0/0", lsu_rvalid, lsu_rdata); end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    tests++; if (ifu_rvalid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL ifu_done got rvalid=%b busy=%b want 0/0", ifu_rvalid, busy); end
  endtask

  task automatic test_lsu_write();
    lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0100;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    #1;
    tests++; if (lsu_ready !== 1'b1 || ifu_ready !== 1'b0) begin fails++; $display("FAIL lsu_wr_accept got lsu=%b ifu=%b want 1/0", lsu_ready, ifu_ready); end
    cyc();
    lsu_valid = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0; mem_ready = 1'b1;
    #1;
    tests++; if ({mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011}) begin fails++; $display("FAIL lsu_wr_req got %h want %h", {mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask}, {1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011}); end
    cyc();
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    #1;
    tests++; if (lsu_rvalid !== 1'b1 || ifu_rvalid !== 1'b0) begin fails++; $display("FAIL lsu_wr_ack got lsu=%b ifu=%b want 1/0", lsu_rvalid, ifu_rvalid); end
    cyc();
    mem_rvalid = 1'b0; lsu_wen = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || lsu_rvalid !== 1'b0) begin fails++; $display("FAIL lsu_wr_3cyc got busy=%b rvalid=%b want 0/0", busy, lsu_rvalid); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL lsu_wr_err got %b want 0", err); end
  endtask

  task automatic test_round_robin();
    logic exp_lsu;
    do_reset();
    ifu_valid = 1'b1; ifu_addr = 32'h0000_1000;
    lsu_valid = 1'b1; lsu_addr = 32'h0000_2000; lsu_wen = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_lsu = (i % 2 == 0);
      #1;
      tests++; if ({lsu_ready, ifu_ready} !== {exp_lsu, !exp_lsu}) begin fails++; $display("FAIL rr_grant t%0d got lsu/ifu=%b%b want %b%b", i, lsu_ready, ifu_ready, exp_lsu, !exp_lsu); end
      cyc();
      tests++; if (mem_addr !== (exp_lsu ? 32'h0000_2000 : 32'h0000_1000) || {lsu_ready, ifu_ready} !== 2'b00) begin fails++; $display("FAIL rr_req t%0d got addr=%h readys=%b%b", i, mem_addr, lsu_ready, ifu_ready); end
      cyc();
      mem_rvalid = 1'b1;
      #1;
      tests++; if ({lsu_rvalid, ifu_rvalid, lsu_ready, ifu_ready} !== {exp_lsu, !exp_lsu, 2'b00}) begin fails++; $display("FAIL rr_rsp t%0d got %b want %b", i, {lsu_rvalid, ifu_rvalid, lsu_ready, ifu_ready}, {exp_lsu, !exp_lsu, 2'b00}); end
      cyc();
      mem_rvalid = 1'b0;
    end
    ifu_valid = 1'b0; lsu_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_stall();
    // last grant was IFU; present IFU alone so it wins, then add LSU.
    ifu_valid = 1'b1; ifu_addr = 32'h8000_0200;
    #1;
    tests++; if (ifu_ready !== 1'b1) begin fails++; $display("FAIL stall_accept got %b want 1", ifu_ready); end
    cyc();
    lsu_valid = 1'b1; lsu_addr = 32'h8000_0300; mem_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      tests++; if ({mem_valid, busy, lsu_ready, mem_addr, mem_wen} !== {1'b1, 1'b1, 1'b0, 32'h8000_0200, 1'b0}) begin fails++; $display("FAIL stall_c%0d got %h want %h", k, {mem_valid, busy, lsu_ready, mem_addr, mem_wen}, {1'b1, 1'b1, 1'b0, 32'h8000_0200, 1'b0}); end
      cyc();
    end
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    tests++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h1234_5678 || lsu_rvalid !== 1'b0) begin fails++; $display("FAIL stall_rsp got %b/%h lsu=%b want 1/12345678 lsu=0", ifu_rvalid, ifu_rdata, lsu_rvalid); end
    ifu_valid = 1'b0; lsu_valid = 1'b0;
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic test_stray_idle();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    tests++; if ({ifu_rvalid, lsu_rvalid} !== 2'b00 || ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin fails++; $display("FAIL stray_rsp got %b%b %h %h want 00 0 0", ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata); end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL stray_err c%0d got %b want 1", k, err); end
      cyc();
    end
    do_reset();
    #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL stray_err_clear got %b want 0", err); end
  endtask

  task automatic test_reset_in_wait();
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0040; lsu_wmask = 4'hF;
    cyc();
    lsu_valid = 1'b0; mem_ready = 1'b1;
    #1;
    tests++; if ({mem_wen, mem_wmask, mem_addr} !== {1'b0, 4'h0, 32'h8000_0040}) begin fails++; $display("FAIL lsu_rd_req got %h want %h", {mem_wen, mem_wmask, mem_addr}, {1'b0, 4'h0, 32'h8000_0040}); end
    cyc();
    mem_ready = 1'b0; rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    tests++; if (lsu_rvalid !== 1'b0 || lsu_rdata !== 32'h0) begin fails++; $display("FAIL rstwait_rsp got %b/%h want 0/0", lsu_rvalid, lsu_rdata); end
    cyc();
    rst = 1'b0; mem_rvalid = 1'b0;
    #1;
    tests++; if ({busy, mem_valid, err} !== 3'b000 || mem_addr !== 32'h0) begin fails++; $display("FAIL rstwait_idle got busy/valid/err=%b addr=%h want 000 0", {busy, mem_valid, err}, mem_addr); end
    mem_rvalid = 1'b1;
    #1;
    tests++; if ({lsu_rvalid, ifu_rvalid} !== 2'b00) begin fails++; $display("FAIL rstwait_late_rsp got %b want 00", {lsu_rvalid, ifu_rvalid}); end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL rstwait_err got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_round_robin();
    test_stall();
    test_stray_idle();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Mutual exclusion of the two ready outputs, checked every cycle.
  always @(negedge clk) begin
    if (ifu_ready && lsu_ready) begin
      fails++;
      $display("FAIL both_ready got 11 want at most one");
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single simulated memory port between the instruction fetch unit (read-only) and the load/store unit (read/write).
- Round-robin arbitration with one outstanding transaction at a time.
- Requests are registered before they reach memory, so address, data and strobe are stable for the whole transfer.
- Sits between ifu/lsu and the memory DPI wrapper.

Parameters:
AW, 32, address width
DW, 32, data width; byte strobe width is DW/8

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_ifu_valid  in  1  IFU read request valid
o_ifu_ready  out  1  IFU request accepted this cycle
i_ifu_addr  in  AW  IFU fetch address
o_ifu_rvalid  out  1  IFU response valid (1 cycle)
o_ifu_rdata  out  DW  IFU response data
i_lsu_valid  in  1  LSU request valid
o_lsu_ready  out  1  LSU request accepted this cycle
i_lsu_wen  in  1  1=write, 0=read
i_lsu_addr  in  AW  LSU address
i_lsu_wdata  in  DW  LSU write data
i_lsu_wmask  in  DW/8  LSU byte strobe
o_lsu_rvalid  out  1  LSU response valid (read data or write ack)
o_lsu_rdata  out  DW  LSU read data
o_mem_valid  out  1  memory request valid
i_mem_ready  in  1  memory accepts request
o_mem_wen  out  1  write enable
o_mem_addr  out  AW  address
o_mem_wdata  out  DW  write data
o_mem_wmask  out  DW/8  strobe; all zero for reads
i_mem_rvalid  in  1  memory response valid
i_mem_rdata  in  DW  memory read data
o_busy  out  1  state != IDLE
o_err  out  1  sticky: i_mem_rvalid seen outside WAIT

Behaviour:

FSM states: IDLE, REQ, WAIT.

Reset (i_rst=1 at a clock edge):
- state=IDLE, last_grant=IFU, o_err=0.
- All request registers cleared, so o_mem_* = 0.
- Any in-flight transaction is dropped; no response is issued for it.

IDLE:
- Ready outputs are driven combinationally, and only in IDLE.
- Only one requester valid: assert that requester's ready.
- Both valid: grant the one not equal to last_grant. After reset, LSU wins the first tie.
- On accept (valid & ready), the next edge:
  - latches owner, wen, addr, wdata, wmask (wen=0 and wmask=0 for IFU),
  - sets last_grant=owner,
  - moves to REQ.
- At most one ready is high in any cycle.

REQ:
- o_mem_valid=1; o_mem_* come from the latched registers and are stable until the handshake.
- i_mem_ready=1 -> WAIT next edge; otherwise stay in REQ.
- Both ready outputs are 0.

WAIT:
- o_mem_valid=0.
- When i_mem_rvalid=1, the same cycle:
  - the owner's rvalid=1 and its rdata=i_mem_rdata (combinational pass-through),
  - the non-owner's rvalid stays 0.
- Next edge -> IDLE.
- Writes also complete with i_mem_rvalid; LSU sees rvalid as an ack, and rdata is don't-care.

Throughput and latency:
- Minimum 3 cycles per transaction (accept, REQ with ready, WAIT with rvalid).
- A new accept is possible in the cycle after rvalid.

Other rules:
- o_ifu_rdata and o_lsu_rdata are 0 whenever the matching rvalid is 0.
- Requesters hold valid and payload stable until ready; changes before acceptance are allowed and are sampled only in the accept cycle.
- i_mem_rvalid in IDLE or REQ is ignored: no response is issued and o_err is set. o_err clears only on reset.
- Simultaneous i_mem_ready and i_mem_rvalid in REQ: ready is honoured; rvalid is treated as stray and sets o_err.
- Reset asserted in REQ or WAIT: the next cycle is IDLE with outputs at reset values.

Test Plan:
1. IFU-only read, addr=0x8000_0000, memory ready after 2 cycles, rdata=0x0000_0413 -> o_ifu_ready pulses once; o_mem_addr stable, wen=0, wmask=0; o_ifu_rvalid one cycle with 0x0000_0413; o_lsu_rvalid stays 0.
2. LSU write, addr=0x8000_0100, wdata=0xDEAD_BEEF, wmask=4'b0011, immediate ready and rvalid -> o_mem_* carry exactly those values; o_lsu_rvalid pulses; the transaction takes 3 cycles.
3. Both valid continuously for 4 transactions -> grant order LSU, IFU, LSU, IFU; never two readys in one cycle.
4. IFU request held while memory keeps i_mem_ready=0 for 10 cycles -> o_mem_valid=1 with constant payload for 10 cycles; o_busy=1 throughout; LSU ready stays 0.
5. i_mem_rvalid pulsed in IDLE -> no rvalid on either requester; o_err=1 until i_rst.
6. i_rst asserted in WAIT, then i_mem_rvalid arrives -> no requester response; state IDLE; o_mem_valid=0; o_err set only if rvalid arrives after reset deasserts.
